// File: rtl/hv_seq_ctrl.sv
// Job sequencer for the accelerator: item-memory write, settle gap, execute, output drain, done pulse.
// Optional watchdog on RUN/DRAIN enabled by defining SEQ_TIMEOUT_EN.
module hv_seq_ctrl #(
  parameter int ITEM_W  = 16,
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              last_in,
  input  logic [ITEM_W-1:0] cfg_items,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [ADDR_W-1:0] cfg_addr_j,
  input  logic              s_fin,
  input  logic              dst_valid,
  input  logic              dst_ready,
  input  logic              dst_last,
  output logic              matw,
  output logic [ITEM_W-1:0] mat_a,
  output logic              run,
  output logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_j,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       beats,
  output logic              err
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_MATW  | item-memory generation, one address per cycle
  // S_GAP   | one settle cycle between generation and execution
  // S_RUN   | execution running, waiting for s_fin
  // S_DRAIN | execution running, counting output beats until dst_last
  // S_DONE  | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MATW  = 3'd1,
    S_GAP   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [ITEM_W-1:0] items;
  logic              beat;
  logic              active;
  logic              accept;
  logic              tmo;

  assign beat   = dst_valid & dst_ready;
  assign active = (state == S_RUN) || (state == S_DRAIN);
  assign accept = (state == S_IDLE) && start && !abort;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] tmr;

  assign tmo = active && (tmr == '0);

  // Down-counter reloaded on the GAP->RUN transition; expiry forces DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr <= '0;
      err <= 1'b0;
    end else begin
      if (state == S_GAP)
        tmr <= TMR_W'(TIMEOUT - 1);
      else if (active && tmr != '0)
        tmr <= tmr - TMR_W'(1);
      if (accept)
        err <= 1'b0;
      else if (tmo && !abort)
        err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (cfg_items == '0) ? S_GAP : S_MATW;
      S_MATW:  if (mat_a == items - ITEM_W'(1)) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_RUN;
      // s_fin wins first; a final beat in the same cycle then completes the drain at once
      S_RUN:   if (s_fin) state_nxt = (beat && dst_last) ? S_DONE : S_DRAIN;
      S_DRAIN: if (beat && dst_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (tmo)
      state_nxt = S_DONE;
    if (abort && state != S_IDLE)
      state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      matw   <= 1'b0;
      run    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mat_a  <= '0;
      items  <= '0;
      addr_i <= '0;
      addr_j <= '0;
      last   <= 1'b0;
      beats  <= '0;
    end else begin
      state <= state_nxt;
      matw  <= (state_nxt == S_MATW);
      run   <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      if (accept) begin
        items  <= cfg_items;
        addr_i <= cfg_addr_i;
        addr_j <= cfg_addr_j;
        last   <= last_in;
        mat_a  <= '0;
        beats  <= '0;
      end else begin
        if (state == S_MATW && state_nxt == S_MATW)
          mat_a <= mat_a + ITEM_W'(1);
        if (active && beat && beats != 16'hFFFF)
          beats <= beats + 16'd1;
      end
    end
  end

endmodule
